// File: rtl/set_job_scheduler_if.sv
// Handshake bundle around set_job_scheduler: job input, engine
// command/response and result output.
interface set_job_scheduler_if #(
    parameter int DEPTH = 4,
    parameter int TAG_W = 4
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic             job_valid;
    logic             job_ready;
    logic [23:0]      job_central;
    logic [11:0]      job_radius;
    logic [1:0]       job_mode;
    logic [TAG_W-1:0] job_tag;

    logic             set_en;
    logic [23:0]      set_central;
    logic [11:0]      set_radius;
    logic [1:0]       set_mode;
    logic             set_busy;
    logic             set_valid;
    logic [7:0]       set_candidate;

    logic             res_valid;
    logic             res_ready;
    logic [7:0]       res_candidate;
    logic [TAG_W-1:0] res_tag;
    logic [1:0]       res_mode;
    logic             res_err;
    logic [CW-1:0]    fifo_cnt;

    modport slave (
        input  job_valid, job_central, job_radius, job_mode, job_tag,
        output job_ready,
        output set_en, set_central, set_radius, set_mode,
        input  set_busy, set_valid, set_candidate,
        output res_valid, res_candidate, res_tag, res_mode, res_err,
        input  res_ready,
        output fifo_cnt
    );

    modport master (
        output job_valid, job_central, job_radius, job_mode, job_tag,
        input  job_ready,
        input  set_en, set_central, set_radius, set_mode,
        output set_busy, set_valid, set_candidate,
        input  res_valid, res_candidate, res_tag, res_mode, res_err,
        output res_ready,
        input  fifo_cnt
    );
endinterface

// File: rtl/set_job_scheduler.sv
// Job FIFO plus issue/wait/return sequencer in front of the
// set-counting engine, with a watchdog on every issued job.
module set_job_scheduler #(
    parameter int DEPTH   = 4,
    parameter int TAG_W   = 4,
    parameter int TIMEOUT = 80
) (
    input logic                clk,
    input logic                rst,
    set_job_scheduler_if.slave bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int EW = 38 + TAG_W;
    localparam int WW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, OUT} state_t;

    state_t           state;
    state_t           state_nx;
    logic [EW-1:0]    mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    cnt;
    logic [WW-1:0]    wd;
    logic [TAG_W-1:0] tag_q;
    logic             full;
    logic             push;
    logic             pop;
    logic             done;

    assign full = (cnt == CW'(DEPTH));
    assign push = bus.job_valid && !full;
    assign pop  = (state == IDLE) && (cnt != '0)
               && !bus.set_busy && !bus.set_valid;
    assign done = (state == WAIT)
               && (bus.set_valid || wd == WW'(TIMEOUT - 1));

    assign bus.job_ready = !full;
    assign bus.fifo_cnt  = cnt;
    assign bus.set_en    = (state == ISSUE);
    assign bus.res_valid = (state == OUT);

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (pop) state_nx = ISSUE;
            ISSUE:   state_nx = WAIT;
            WAIT:    if (done) state_nx = OUT;
            OUT:     if (bus.res_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= {bus.job_central, bus.job_radius,
                            bus.job_mode, bus.job_tag};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state             <= IDLE;
            wr_ptr            <= '0;
            rd_ptr            <= '0;
            cnt               <= '0;
            wd                <= '0;
            tag_q             <= '0;
            bus.set_central   <= '0;
            bus.set_radius    <= '0;
            bus.set_mode      <= '0;
            bus.res_candidate <= '0;
            bus.res_tag       <= '0;
            bus.res_mode      <= '0;
            bus.res_err       <= 1'b0;
        end else begin
            state <= state_nx;
            cnt   <= cnt + CW'(push) - CW'(pop);
            if (push)
                wr_ptr <= wr_ptr + PW'(1);
            if (pop)
                rd_ptr <= rd_ptr + PW'(1);
            // counting starts in ISSUE so a timeout lands TIMEOUT cycles after set_en
            if (pop) begin
                {bus.set_central, bus.set_radius,
                 bus.set_mode, tag_q} <= mem[rd_ptr];
                wd <= '0;
            end else if (state == ISSUE || state == WAIT) begin
                wd <= wd + WW'(1);
            end
            if (done) begin
                bus.res_candidate <= bus.set_valid ? bus.set_candidate : 8'd0;
                bus.res_err       <= !bus.set_valid;
                bus.res_tag       <= tag_q;
                bus.res_mode      <= bus.set_mode;
            end
        end
    end
endmodule

// File: doc/set_job_scheduler.md
Name: set_job_scheduler

Overview:
- Upstream command stage for the set-counting engine, i.e. the block that counts lattice points inside circle combinations.
- Accepts jobs (central/radius/mode plus a tag) over a valid/ready handshake and buffers them in a small FIFO.
- Issues one job at a time to the engine via a single-cycle enable, waits for the engine's valid pulse, and returns the candidate count with its tag on a valid/ready result port.
- A watchdog turns a hung job into an error result.

Parameters:
- DEPTH, 4, job FIFO entries (power of 2, >=2)
- TAG_W, 4, job tag width
- TIMEOUT, 80, max cycles waited for engine valid after enable (engine nominal ~74)

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  asynchronous active-low reset
- job_valid  in  1  job offered
- job_ready  out  1  FIFO can accept (= !full)
- job_central  in  24  {Ax,Ay,Bx,By,Cx,Cy}, 4 bits each
- job_radius  in  12  {ra,rb,rc}
- job_mode  in  2  engine mode 0..3
- job_tag  in  TAG_W  caller tag
- set_en  out  1  one-cycle start pulse to engine
- set_central  out  24  held stable from issue until result captured
- set_radius  out  12  as above
- set_mode  out  2  as above
- set_busy  in  1  engine busy
- set_valid  in  1  engine result pulse
- set_candidate  in  8  engine count
- res_valid  out  1  result available
- res_ready  in  1  consumer accepts
- res_candidate  out  8  captured count (0 on error)
- res_tag  out  TAG_W  tag of the job
- res_mode  out  2  mode of the job
- res_err  out  1  1 = watchdog timeout
- fifo_cnt  out  clog2(DEPTH)+1  current FIFO occupancy

Behaviour:
- Reset (rst=0, async): FSM=IDLE; FIFO empty; fifo_cnt=0; job_ready=1; set_en=0; set_central/radius/mode=0; res_valid=0; res_candidate=0; res_tag=0; res_mode=0; res_err=0; watchdog=0. Reset mid-job drops all queued and in-flight jobs; no result is emitted.
- FIFO:
  - Push when job_valid && job_ready. Pop only on the IDLE->ISSUE transition.
  - job_ready=0 when full; no push-while-full bypass, even if a pop occurs in the same cycle.
  - Simultaneous push and pop: fifo_cnt unchanged.
  - Pointers wrap modulo DEPTH.
  - A pushed entry is visible to IDLE the next cycle.
- FSM (registered, Moore outputs):
  - IDLE: if fifo_cnt!=0 && !set_busy && !set_valid, load the head into set_central/radius/mode, capture tag/mode internally, pop, go ISSUE; else stay.
  - ISSUE: set_en=1 for exactly this cycle; watchdog cleared; go WAIT.
  - WAIT:
    - watchdog increments each cycle; set_busy is ignored.
    - If set_valid=1: res_candidate<=set_candidate, res_err<=0, go OUT.
    - Else if watchdog==TIMEOUT-1: res_candidate<=0, res_err<=1, go OUT.
    - set_valid takes priority when both occur in the same cycle.
  - OUT:
    - res_valid=1; res_tag/res_mode/res_candidate/res_err held stable.
    - On res_ready=1 go IDLE, and res_valid is 0 the next cycle.
    - Backpressure is unbounded; FIFO pushes continue meanwhile.
- A set_valid arriving outside WAIT is ignored.
- set_* data outputs change only on IDLE->ISSUE.
- Minimum job-to-result latency with an empty queue, engine idle, and res_ready=1:
  - push at cycle t
  - ISSUE (set_en) at t+2
  - res_valid one cycle after set_valid
- Back-to-back jobs: the next set_en comes no earlier than 2 cycles after the previous result handshake. This guarantees engine busy has dropped.
- Results return in issue order; exactly one result per accepted job.

Test Plan:
- Single job mode0, central=24'h44_0000, radius=12'h200, engine model returns 13 after 73 cycles -> one set_en pulse at t+2; res_valid with res_candidate=8'd13, res_err=0, res_mode=0, tag echoed.
- Push 5 jobs back-to-back with DEPTH=4 and engine busy on job 1 -> job_ready low after 4 queued; fifo_cnt peaks at 4; all 5 results emerge in tag order 0..4 with the model's counts.
- Engine model never asserts set_valid -> res_valid with res_err=1 and res_candidate=0 exactly TIMEOUT=80 cycles after set_en; the next queued job issues normally.
- Hold res_ready=0 for 200 cycles with 3 queued jobs -> first result stable throughout; no further set_en; fifo_cnt=2 (queue intact); results then drain one per handshake.
- Assert rst=0 asynchronously during WAIT with 2 queued jobs -> all outputs reach reset values immediately; no result after release; fresh job completes normally.
- set_valid in the same cycle as watchdog expiry -> res_err=0 and res_candidate equals the engine value.
